// File: rtl/i4001_rom_if.sv
// MCS-4 system-bus view of one memory chip: CPU timing strobes, resolved bus, and this chip's drive.
interface i4001_rom_if;
  logic       sync;
  logic       cm_rom;
  logic [3:0] bus_in;
  logic [3:0] bus_out;
  logic       bus_oe;

  modport master (output sync, cm_rom, bus_in, input bus_out, bus_oe);
  modport slave  (input sync, cm_rom, bus_in, output bus_out, bus_oe);
endinterface

// File: rtl/i4001_rom.sv
// MCS-4 program ROM (256x8) with one 4-bit I/O port, SRC-selected and accessed by WRR/RDR.
// The chip snoops every instruction on the shared bus so all instances agree on two-word state.
//
// phase  | meaning
// UNSYNC | after reset, waiting for the first sync; never drives the bus
// A1..A3 | address low nibble, high nibble, chip-number nibble
// M1,M2  | opcode nibbles OPR, OPA (driven by the selected ROM)
// X1..X3 | execute; I/O data on the bus in X2, sync high during X3
module i4001_rom #(
  parameter logic [3:0] CHIP_ID     = 4'h0,
  parameter logic [3:0] IO_OUT_MASK = 4'b0000,
  parameter string      INIT_FILE   = ""
) (
  input  logic       clk,
  input  logic       rst,
  i4001_rom_if.slave bus,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
);

  typedef enum logic [3:0] {
    A1     = 4'd0,
    A2     = 4'd1,
    A3     = 4'd2,
    M1     = 4'd3,
    M2     = 4'd4,
    X1     = 4'd5,
    X2     = 4'd6,
    X3     = 4'd7,
    UNSYNC = 4'd8
  } phase_t;

  phase_t     phase, phase_nx;
  logic [7:0] rom [256];
  logic [7:0] addr;
  logic [7:0] rom_q;
  logic       fetch_sel;
  logic [3:0] opr, opa;
  logic       second_word;
  logic       src_sel;
  logic [3:0] io_out_q;
  logic       is_src, is_wrr, is_rdr, two_word;
  logic [3:0] bus_out_c;
  logic       bus_oe_c;

  always_ff @(posedge clk) begin
    if (rst) phase <= UNSYNC;
    else     phase <= phase_nx;
  end

  always_comb begin
    phase_nx = phase;
    if (bus.sync) begin
      phase_nx = A1;
    end else begin
      case (phase)
        A1:      phase_nx = A2;
        A2:      phase_nx = A3;
        A3:      phase_nx = M1;
        M1:      phase_nx = M2;
        M2:      phase_nx = X1;
        X1:      phase_nx = X2;
        X2:      phase_nx = X3;
        X3:      phase_nx = A1;
        default: phase_nx = UNSYNC;
      endcase
    end
  end

  // Back-door writes use no reset so ROM contents survive a CPU reset.
  always_ff @(posedge clk) begin
    if (prog_we) rom[prog_addr] <= prog_data;
  end

  // The data word of a two-word instruction is never decoded as SRC or I/O.
  assign is_src   = !second_word && opr == 4'h2 && opa[0] && bus.cm_rom;
  assign is_wrr   = !second_word && src_sel && opr == 4'hE && opa == 4'h2;
  assign is_rdr   = !second_word && src_sel && opr == 4'hE && opa == 4'hA;
  assign two_word = (opr == 4'h1 || opr == 4'h4 || opr == 4'h5 || opr == 4'h7) ||
                    ((opr == 4'h2 || opr == 4'h3) && !opa[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      rom_q       <= '0;
      fetch_sel   <= 1'b0;
      opr         <= '0;
      opa         <= '0;
      second_word <= 1'b0;
      src_sel     <= 1'b0;
      io_out_q    <= '0;
    end else begin
      case (phase)
        A1: addr[3:0] <= bus.bus_in;
        A2: addr[7:4] <= bus.bus_in;
        A3: begin
          fetch_sel <= bus.cm_rom && (bus.bus_in == CHIP_ID);
          rom_q     <= rom[addr];
        end
        M1: opr <= bus.bus_in;
        M2: opa <= bus.bus_in;
        // A sync here means the cycle is being abandoned, so no side effects.
        X2: if (!bus.sync) begin
          if (is_src) src_sel  <= (bus.bus_in == CHIP_ID);
          if (is_wrr) io_out_q <= bus.bus_in & IO_OUT_MASK;
        end
        X3: second_word <= !second_word && two_word;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_out_c = '0;
    bus_oe_c  = 1'b0;
    case (phase)
      M1: if (fetch_sel) begin
        bus_oe_c  = 1'b1;
        bus_out_c = rom_q[7:4];
      end
      M2: if (fetch_sel) begin
        bus_oe_c  = 1'b1;
        bus_out_c = rom_q[3:0];
      end
      X2: if (is_rdr) begin
        bus_oe_c  = 1'b1;
        bus_out_c = (io_in & ~IO_OUT_MASK) | (io_out_q & IO_OUT_MASK);
      end
      default: ;
    endcase
  end

  assign bus.bus_out = bus_out_c;
  assign bus.bus_oe  = bus_oe_c;
  assign io_out      = io_out_q;

endmodule

// File: tb/tb_i4001_rom.sv
// Three i4001_rom chips (ids 0,1,2) sharing one wired-OR bus, driven phase by phase
// and checked against a per-instruction-cycle reference model plus a fixed vector table.
`timescale 1ns/1ps
module tb_i4001_rom;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sync, cm_rom;
  logic [3:0] cpu_bus;
  logic [3:0] bus;
  logic [3:0] io_in  [3];
  logic [3:0] io_out [3];
  logic [2:0] prog_we;
  logic [7:0] prog_addr, prog_data;

  i4001_rom_if if0 ();
  i4001_rom_if if1 ();
  i4001_rom_if if2 ();

  assign bus = cpu_bus | if0.bus_out | if1.bus_out | if2.bus_out;
  assign if0.sync = sync;  assign if0.cm_rom = cm_rom;  assign if0.bus_in = bus;
  assign if1.sync = sync;  assign if1.cm_rom = cm_rom;  assign if1.bus_in = bus;
  assign if2.sync = sync;  assign if2.cm_rom = cm_rom;  assign if2.bus_in = bus;

  logic [2:0] oe_w;
  logic [3:0] bo_w [3];
  assign oe_w    = {if2.bus_oe, if1.bus_oe, if0.bus_oe};
  assign bo_w[0] = if0.bus_out;
  assign bo_w[1] = if1.bus_out;
  assign bo_w[2] = if2.bus_out;

  i4001_rom #(.CHIP_ID(4'h0), .IO_OUT_MASK(4'hF)) u0 (
    .clk(clk), .rst(rst), .bus(if0), .io_in(io_in[0]), .io_out(io_out[0]),
    .prog_we(prog_we[0]), .prog_addr(prog_addr), .prog_data(prog_data));
  i4001_rom #(.CHIP_ID(4'h1), .IO_OUT_MASK(4'b0011)) u1 (
    .clk(clk), .rst(rst), .bus(if1), .io_in(io_in[1]), .io_out(io_out[1]),
    .prog_we(prog_we[1]), .prog_addr(prog_addr), .prog_data(prog_data));
  i4001_rom #(.CHIP_ID(4'h2), .IO_OUT_MASK(4'b0000)) u2 (
    .clk(clk), .rst(rst), .bus(if2), .io_in(io_in[2]), .io_out(io_out[2]),
    .prog_we(prog_we[2]), .prog_addr(prog_addr), .prog_data(prog_data));

  // Reference model: instruction-level view of ROM images, SRC selection, port latches.
  logic [7:0] m_rom [3][256];
  bit         m_src [3];
  logic [3:0] m_io  [3];
  bit         m_second;

  int checks   = 0;
  int failures = 0;

  function automatic logic [3:0] mask_of(input int c);
    case (c)
      0:       return 4'hF;
      1:       return 4'h3;
      default: return 4'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic cm, input logic s);
    @(posedge clk);
    #1;
    cpu_bus = b;
    cm_rom  = cm;
    sync    = s;
    @(negedge clk);
  endtask

  task automatic prog_write(input int c, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    prog_we   = 3'(1 << c);
    prog_addr = a;
    prog_data = d;
    m_rom[c][a] = d;
    @(negedge clk);
  endtask

  task automatic prog_done();
    @(posedge clk);
    #1;
    prog_we = 3'b000;
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_src[c] = 1'b0;
      m_io[c]  = 4'h0;
    end
    m_second = 1'b0;
  endtask

  // One instruction cycle; sync_at is the phase index (0=A1..7=X3) carrying sync.
  task automatic do_cycle(input logic [7:0] a, input logic [3:0] chip, input logic cm_a3,
                          input logic [3:0] x2b, input logic cm_x2, input int sync_at,
                          output logic [3:0] m1, output logic [3:0] m2, output logic [3:0] x2);
    int         drv;
    logic [7:0] byte_v;
    logic [3:0] opr_v, opa_v, x2_bus, pb;
    logic       pc, eoe;
    logic [3:0] eo;
    logic       rdr   [3];
    logic [3:0] rdr_v [3];
    drv    = (cm_a3 && chip < 4'd3) ? int'(chip) : -1;
    byte_v = (drv >= 0) ? m_rom[drv][a] : 8'h00;
    opr_v  = byte_v[7:4];
    opa_v  = byte_v[3:0];
    x2_bus = x2b;
    for (int c = 0; c < 3; c++) begin
      rdr[c]   = !m_second && byte_v == 8'hEA && m_src[c];
      rdr_v[c] = (io_in[c] & ~mask_of(c)) | (m_io[c] & mask_of(c));
      if (rdr[c]) x2_bus = x2_bus | rdr_v[c];
    end
    m1 = 4'h0;
    m2 = 4'h0;
    x2 = 4'h0;
    for (int p = 0; p <= sync_at; p++) begin
      case (p)
        0:       pb = a[3:0];
        1:       pb = a[7:4];
        2:       pb = chip;
        6:       pb = x2b;
        default: pb = 4'h0;
      endcase
      pc = (p == 2) ? cm_a3 : ((p == 6) ? cm_x2 : 1'b0);
      step(pb, pc, p == sync_at);
      if (p == 3) m1 = bus;
      if (p == 4) m2 = bus;
      if (p == 6) x2 = bus;
      for (int c = 0; c < 3; c++) begin
        eoe = 1'b0;
        eo  = 4'h0;
        if (p == 3 && c == drv) begin eoe = 1'b1; eo = opr_v; end
        if (p == 4 && c == drv) begin eoe = 1'b1; eo = opa_v; end
        if (p == 6 && rdr[c])   begin eoe = 1'b1; eo = rdr_v[c]; end
        chk($sformatf("drive_c%0d_p%0d addr=%0h", c, p, a),
            32'({oe_w[c], bo_w[c]}), 32'({eoe, eo}));
      end
    end
    if (sync_at == 7) begin
      for (int c = 0; c < 3; c++) begin
        if (!m_second && byte_v == 8'hE2 && m_src[c]) m_io[c] = x2_bus & mask_of(c);
        if (!m_second && opr_v == 4'h2 && opa_v[0] && cm_x2) m_src[c] = (x2_bus == 4'(c));
      end
      m_second = !m_second && ((opr_v inside {4'h1, 4'h4, 4'h5, 4'h7}) ||
                               ((opr_v inside {4'h2, 4'h3}) && !opa_v[0]));
    end
    for (int c = 0; c < 3; c++)
      chk($sformatf("io_out_c%0d", c), 32'(io_out[c]), 32'(m_io[c]));
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [3:0] chip;
    logic [3:0] x2b;
    logic       cm_x2;
    logic [3:0] m1, m2, x2, io0, io1;
  } vec_t;

  vec_t tbl [18];

  logic [7:0] pick [12] = '{8'h21, 8'h23, 8'hE2, 8'hEA, 8'h20, 8'h40,
                            8'h12, 8'hA7, 8'h30, 8'h71, 8'hE1, 8'h5F};

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] m1, m2, x2;
    logic [7:0] ra;
    logic [3:0] rc;
    int         sa;

    //          addr   chip  x2b   cm    m1    m2    x2    io0   io1
    tbl[0]  = '{8'h35, 4'h0, 4'h0, 1'b0, 4'hA, 4'h7, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{8'h35, 4'h1, 4'h0, 1'b0, 4'h5, 4'hC, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{8'h17, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{8'h10, 4'h0, 4'h0, 1'b1, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{8'h11, 4'h0, 4'h9, 1'b0, 4'hE, 4'h2, 4'h9, 4'h9, 4'h0};
    tbl[5]  = '{8'h10, 4'h0, 4'h3, 1'b1, 4'h2, 4'h1, 4'h3, 4'h9, 4'h0};
    tbl[6]  = '{8'h11, 4'h0, 4'h4, 1'b0, 4'hE, 4'h2, 4'h4, 4'h9, 4'h0};
    tbl[7]  = '{8'h10, 4'h0, 4'h1, 1'b1, 4'h2, 4'h1, 4'h1, 4'h9, 4'h0};
    tbl[8]  = '{8'h11, 4'h1, 4'h3, 1'b0, 4'hE, 4'h2, 4'h3, 4'h9, 4'h3};
    tbl[9]  = '{8'h12, 4'h1, 4'h0, 1'b0, 4'hE, 4'hA, 4'hF, 4'h9, 4'h3};
    tbl[10] = '{8'h10, 4'h0, 4'h2, 1'b1, 4'h2, 4'h1, 4'h2, 4'h9, 4'h3};
    tbl[11] = '{8'h12, 4'h2, 4'h0, 1'b0, 4'hE, 4'hA, 4'h6, 4'h9, 4'h3};
    tbl[12] = '{8'h10, 4'h0, 4'h0, 1'b1, 4'h2, 4'h1, 4'h0, 4'h9, 4'h3};
    tbl[13] = '{8'h13, 4'h0, 4'h0, 1'b0, 4'h2, 4'h0, 4'h0, 4'h9, 4'h3};
    tbl[14] = '{8'h14, 4'h0, 4'h5, 1'b0, 4'hE, 4'h2, 4'h5, 4'h9, 4'h3};
    tbl[15] = '{8'h15, 4'h0, 4'h0, 1'b0, 4'h4, 4'h0, 4'h0, 4'h9, 4'h3};
    tbl[16] = '{8'h16, 4'h0, 4'h2, 1'b1, 4'h2, 4'h1, 4'h2, 4'h9, 4'h3};
    tbl[17] = '{8'h11, 4'h0, 4'h6, 1'b0, 4'hE, 4'h2, 4'h6, 4'h6, 4'h3};

    for (int c = 0; c < 3; c++)
      for (int a = 0; a < 256; a++) m_rom[c][a] = 8'h00;
    model_reset();

    rst = 1'b1; sync = 1'b0; cm_rom = 1'b0; cpu_bus = 4'h0;
    prog_we = 3'b000; prog_addr = 8'h00; prog_data = 8'h00;
    io_in[0] = 4'h0; io_in[1] = 4'b1100; io_in[2] = 4'h6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_oe", 32'(oe_w), 32'(0));
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("reset_bus_out_c%0d", c), 32'(bo_w[c]), 32'(0));
      chk($sformatf("reset_io_out_c%0d", c), 32'(io_out[c]), 32'(0));
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Program the images while the chips are still unsynchronised.
    prog_write(0, 8'h35, 8'hA7); prog_write(0, 8'h10, 8'h21); prog_write(0, 8'h11, 8'hE2);
    prog_write(0, 8'h12, 8'hEA); prog_write(0, 8'h13, 8'h20); prog_write(0, 8'h14, 8'hE2);
    prog_write(0, 8'h15, 8'h40); prog_write(0, 8'h16, 8'h21); prog_write(0, 8'h17, 8'h00);
    prog_write(1, 8'h35, 8'h5C); prog_write(1, 8'h11, 8'hE2); prog_write(1, 8'h12, 8'hEA);
    prog_write(2, 8'h12, 8'hEA);
    for (int c = 0; c < 3; c++)
      for (int a = 128; a < 256; a++)
        prog_write(c, 8'(a), pick[$urandom_range(0, 11)]);
    prog_done();

    for (int i = 0; i < 4; i++) begin
      step(4'($urandom), 1'b1, 1'b0);
      chk("unsync_no_drive", 32'(oe_w), 32'(0));
    end
    step(4'h0, 1'b0, 1'b1);

    for (int i = 0; i < 18; i++) begin
      do_cycle(tbl[i].addr, tbl[i].chip, 1'b1, tbl[i].x2b, tbl[i].cm_x2, 7, m1, m2, x2);
      chk($sformatf("vec%0d_m1", i), 32'(m1), 32'(tbl[i].m1));
      chk($sformatf("vec%0d_m2", i), 32'(m2), 32'(tbl[i].m2));
      chk($sformatf("vec%0d_x2", i), 32'(x2), 32'(tbl[i].x2));
      chk($sformatf("vec%0d_io0", i), 32'(io_out[0]), 32'(tbl[i].io0));
      chk($sformatf("vec%0d_io1", i), 32'(io_out[1]), 32'(tbl[i].io1));
    end

    // Reset asserted during M1 of a fetch from chip 0.
    step(4'h5, 1'b0, 1'b0);
    step(4'h3, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cpu_bus = 4'h0; cm_rom = 1'b0; sync = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_m1_drive", 32'({oe_w[0], bo_w[0]}), 32'(5'h1A));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("after_rst_oe", 32'(oe_w), 32'(0));
    chk("after_rst_io0", 32'(io_out[0]), 32'(0));
    chk("after_rst_io1", 32'(io_out[1]), 32'(0));
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'($urandom), 1'b1, 1'b0);
      chk("post_rst_unsync_no_drive", 32'(oe_w), 32'(0));
    end
    step(4'h0, 1'b0, 1'b1);
    do_cycle(8'h35, 4'h0, 1'b1, 4'h0, 1'b0, 7, m1, m2, x2);
    chk("post_rst_fetch_m1", 32'(m1), 32'(4'hA));
    chk("post_rst_fetch_m2", 32'(m2), 32'(4'h7));

    // Short cycles: sync after five phases, and an abandoned WRR.
    do_cycle(8'h35, 4'h0, 1'b1, 4'h0, 1'b0, 4, m1, m2, x2);
    chk("short_cycle_m1", 32'(m1), 32'(4'hA));
    do_cycle(8'h35, 4'h0, 1'b1, 4'h0, 1'b0, 7, m1, m2, x2);
    chk("after_short_m1", 32'(m1), 32'(4'hA));
    chk("after_short_m2", 32'(m2), 32'(4'h7));
    do_cycle(8'h10, 4'h0, 1'b1, 4'h0, 1'b1, 7, m1, m2, x2);
    do_cycle(8'h11, 4'h0, 1'b1, 4'h5, 1'b0, 5, m1, m2, x2);
    chk("abandoned_wrr_io0", 32'(io_out[0]), 32'(0));
    do_cycle(8'h11, 4'h0, 1'b1, 4'hC, 1'b0, 7, m1, m2, x2);
    chk("wrr_after_abandon_io0", 32'(io_out[0]), 32'(4'hC));

    for (int n = 0; n < 150; n++) begin
      for (int c = 0; c < 3; c++) io_in[c] = 4'($urandom);
      ra = 8'($urandom_range(128, 255));
      rc = 4'($urandom_range(0, 3));
      sa = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 4 : 5) : 7;
      do_cycle(ra, rc, $urandom_range(0, 7) != 0, 4'($urandom), 1'($urandom), sa, m1, m2, x2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
